// File: rtl/sbox_array_if.sv
// Handshake bundle for sbox_array: input word channel, result channel and transfer count.
// master = producer/consumer side, slave = the substitution block.
interface sbox_array_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_inv;
  logic [8*LANES-1:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_inv;
  logic [8*LANES-1:0]   out_data;
  logic [CNT_W-1:0]     xfer_cnt;

  modport master (
    output in_valid, in_inv, in_data, out_ready,
    input  in_ready, out_valid, out_inv, out_data, xfer_cnt
  );

  modport slave (
    input  in_valid, in_inv, in_data, out_ready,
    output in_ready, out_valid, out_inv, out_data, xfer_cnt
  );
endinterface

// File: rtl/sbox_array.sv
// Two-stage pipelined AES forward/inverse S-box over LANES byte lanes.
// Lookup is computed as GF(2^8) inversion wrapped by the affine map, selected per word.
module sbox_array #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  sbox_array_if.slave  bus
);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holding valid keeps its payload stable, and ready never depends on valid.

  logic                 r_run;
  logic                 r_s1_valid;
  logic                 r_s1_inv;
  logic [8*LANES-1:0]   r_s1_data;
  logic                 r_s2_valid;
  logic                 r_s2_inv;
  logic [8*LANES-1:0]   r_s2_data;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_stall;
  logic                 w_s1_load;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_out_fire;
  logic [8*LANES-1:0]   w_sub;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1b) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); zero maps to zero as the cipher requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] t;
    t = inv ? inv_affine(x) : x;
    t = gf_inv(t);
    return inv ? t : affine(t);
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_sub[8*k +: 8] = sbox(r_s1_data[8*k +: 8], r_s1_inv);
  end

  assign w_stall    = r_s2_valid & ~bus.out_ready;
  assign w_s1_load  = ~r_s1_valid | ~w_stall;
  assign w_in_ready = r_run & w_s1_load;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_out_fire = r_s2_valid & bus.out_ready;

  // r_run keeps in_ready low during reset and for the edge that follows release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_data  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_inv   <= 1'b0;
      r_s2_data  <= '0;
      r_cnt      <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_s1_data <= bus.in_data;
        r_s1_inv  <= bus.in_inv;
      end
      if (w_s1_load) r_s1_valid <= w_accept;
      if (!w_stall) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_sub;
          r_s2_inv  <= r_s1_inv;
        end
      end
      if (w_out_fire) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_inv   = r_s2_inv;
  assign bus.out_data  = r_s2_data;
  assign bus.xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_sbox_array.sv
// Directed bench for sbox_array: four instances (4/16-bit count, 4/4-bit count, 1 lane, 16 lanes)
// share one stimulus stream; results are checked against a literal FIPS-197 table.
module tb_sbox_array;

  localparam logic [2047:0] FWD_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_ready;

  logic [7:0]   fwd_tab [0:255];
  logic [7:0]   inv_tab [0:255];

  logic [128:0] exp_q [$];
  int           lat_q [$];
  int           checks;
  int           errors;
  int           step_n;
  logic         chk_lat;
  logic [15:0]  exp_cnt;
  logic         prev_stall;
  logic [32:0]  prev_out;

  sbox_array_if #(.LANES(4),  .CNT_W(16)) if_m  ();
  sbox_array_if #(.LANES(4),  .CNT_W(4))  if_w  ();
  sbox_array_if #(.LANES(1),  .CNT_W(16)) if_1  ();
  sbox_array_if #(.LANES(16), .CNT_W(16)) if_16 ();

  assign if_m.in_valid   = in_valid;
  assign if_m.in_inv     = in_inv;
  assign if_m.in_data    = in_data[31:0];
  assign if_m.out_ready  = out_ready;
  assign if_w.in_valid   = in_valid;
  assign if_w.in_inv     = in_inv;
  assign if_w.in_data    = in_data[31:0];
  assign if_w.out_ready  = out_ready;
  assign if_1.in_valid   = in_valid;
  assign if_1.in_inv     = in_inv;
  assign if_1.in_data    = in_data[7:0];
  assign if_1.out_ready  = out_ready;
  assign if_16.in_valid  = in_valid;
  assign if_16.in_inv    = in_inv;
  assign if_16.in_data   = in_data;
  assign if_16.out_ready = out_ready;

  sbox_array #(.LANES(4),  .CNT_W(16)) u_dut_m  (.clk(clk), .rst_n(rst_n), .bus(if_m));
  sbox_array #(.LANES(4),  .CNT_W(4))  u_dut_w  (.clk(clk), .rst_n(rst_n), .bus(if_w));
  sbox_array #(.LANES(1),  .CNT_W(16)) u_dut_1  (.clk(clk), .rst_n(rst_n), .bus(if_1));
  sbox_array #(.LANES(16), .CNT_W(16)) u_dut_16 (.clk(clk), .rst_n(rst_n), .bus(if_16));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] sub128(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = d[8*k +: 8];
      r[8*k +: 8] = inv ? inv_tab[b] : fwd_tab[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] exh_word(input int b);
    logic [127:0] d;
    logic [7:0]   bb;
    logic [7:0]   kk;
    bb = 8'(b);
    d  = '0;
    for (int k = 0; k < 16; k++) begin
      kk = 8'(k * 17);
      d[8*k +: 8] = bb ^ kk;
    end
    return d;
  endfunction

  // driver + scoreboard: drive at negedge, sample 1 ns later, then advance one clock
  task automatic step(input logic v, input logic [127:0] d, input logic inv, input logic ordy,
                      output logic acc);
    logic [128:0] e;
    in_valid  = v;
    in_data   = d;
    in_inv    = inv;
    out_ready = ordy;
    #1;
    if (prev_stall) chk("stall_hold", 132'({if_m.out_valid, if_m.out_inv, if_m.out_data}),
                        132'({1'b1, prev_out}));
    chk("in_ready", 132'(if_m.in_ready), 132'(!(exp_q.size() == 2 && !ordy)));
    chk("xfer_cnt", 132'(if_m.xfer_cnt), 132'(exp_cnt));
    chk("xfer_cnt_w", 132'(if_w.xfer_cnt), 132'(exp_cnt[3:0]));
    if (if_m.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("extra_out", 132'(if_m.out_valid), 132'(0));
      end else begin
        e = exp_q.pop_front();
        chk("out_m", 132'({if_m.out_inv, if_m.out_data}), 132'({e[128], e[31:0]}));
        chk("out_w", 132'({if_w.out_inv, if_w.out_data}), 132'({e[128], e[31:0]}));
        chk("out_l1", 132'({if_1.out_inv, if_1.out_data}), 132'({e[128], e[7:0]}));
        chk("out_l16", 132'({if_16.out_inv, if_16.out_data}), 132'(e));
        if (chk_lat) chk("latency", 132'(step_n - lat_q.pop_front()), 132'(2));
        else void'(lat_q.pop_front());
        exp_cnt++;
      end
    end
    acc = v && if_m.in_ready;
    if (acc) begin
      exp_q.push_back({inv, sub128(d, inv)});
      lat_q.push_back(step_n);
    end
    prev_stall = if_m.out_valid && !ordy;
    prev_out   = {if_m.out_inv, if_m.out_data};
    @(posedge clk);
    @(negedge clk);
    step_n++;
  endtask

  logic [31:0] bp_d [0:9];
  logic        bp_i [0:9];

  initial begin
    logic [2047:0] rom;
    logic          acc;
    int            n;
    int            guard;

    rom = FWD_ROM;
    for (int i = 0; i < 256; i++) fwd_tab[i] = rom[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    bp_d = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 32'h63edfe16,
             32'hdeadbeef, 32'h01020304, 32'hf0e1d2c3, 32'h5a5aa5a5, 32'h7f80817e};
    bp_i = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    checks = 0; errors = 0; step_n = 0; chk_lat = 1'b1;
    exp_cnt = '0; prev_stall = 1'b0; prev_out = '0;

    // reset state
    rst_n = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 132'(if_m.out_valid), 132'(0));
    chk("rst_out_data", 132'(if_m.out_data), 132'(0));
    chk("rst_out_inv", 132'(if_m.out_inv), 132'(0));
    chk("rst_xfer_cnt", 132'(if_m.xfer_cnt), 132'(0));
    chk("rst_in_ready", 132'(if_m.in_ready), 132'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_in_ready", 132'(if_m.in_ready), 132'(1));
    chk("rel_out_valid", 132'(if_m.out_valid), 132'(0));

    // exhaustive sweep, both modes, out_ready held high
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < 256; b++) step(1'b1, exh_word(b), m[0], 1'b1, acc);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("exh_drain", 132'(exp_q.size()), 132'(0));

    // round trip 0x00530cff -> 0x63edfe16 -> 0x00530cff
    step(1'b1, 128'h00530cff, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("rt_fwd", 132'({if_m.out_valid, if_m.out_inv, if_m.out_data}), 132'({2'b10, 32'h63edfe16}));
    chk("fwd_0c", 132'(if_m.out_data[15:8]), 132'(8'hfe));
    step(1'b1, 128'h63edfe16, 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("rt_inv", 132'({if_m.out_valid, if_m.out_inv, if_m.out_data}), 132'({2'b11, 32'h00530cff}));
    repeat (2) step(1'b0, '0, 1'b0, 1'b1, acc);

    // backpressure with pseudo-random out_ready
    chk_lat = 1'b0;
    n = 0; guard = 0;
    while (n < 10 && guard < 200) begin
      step(1'b1, {96'b0, bp_d[n]}, bp_i[n], 1'($urandom_range(0, 1)), acc);
      if (acc) n++;
      guard++;
    end
    chk("bp_accepted", 132'(n), 132'(10));
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      step(1'b0, '0, 1'b0, 1'($urandom_range(0, 1)), acc);
      guard++;
    end
    chk("bp_drain", 132'(exp_q.size()), 132'(0));

    // full stall: only two words fit
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, {96'b0, 32'ha0b0c0d0 + 32'(i)}, 1'(i), 1'b0, acc);
      if (acc) n++;
    end
    chk("stall_accepts", 132'(n), 132'(2));
    chk("stall_in_ready", 132'(if_m.in_ready), 132'(0));
    step(1'b1, 128'h11223344, 1'b0, 1'b1, acc);
    chk("resume_accept", 132'(acc), 132'(1));
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("stall_drain", 132'(exp_q.size()), 132'(0));

    // asynchronous reset with two words in flight
    step(1'b1, 128'hcafef00d, 1'b0, 1'b0, acc);
    step(1'b1, 128'h0badc0de, 1'b1, 1'b0, acc);
    chk("pre_rst_valid", 132'(if_m.out_valid), 132'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 132'(if_m.out_valid), 132'(0));
    chk("arst_xfer_cnt", 132'(if_m.xfer_cnt), 132'(0));
    chk("arst_in_ready", 132'(if_m.in_ready), 132'(0));
    chk("arst_out_data", 132'(if_m.out_data), 132'(0));
    exp_q.delete(); lat_q.delete(); exp_cnt = '0; prev_stall = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("arel_in_ready", 132'(if_m.in_ready), 132'(1));
    chk("arel_out_valid", 132'(if_m.out_valid), 132'(0));
    repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("arel_quiet", 132'(if_m.out_valid), 132'(0));

    // 4-bit counter wraps after 16 handshakes
    chk_lat = 1'b1;
    for (int i = 0; i < 17; i++) step(1'b1, {96'b0, 32'(i) * 32'h01010101}, 1'(i), 1'b1, acc);
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, acc);
    chk("wrap_cnt_w", 132'(if_w.xfer_cnt), 132'(1));
    chk("wrap_cnt_m", 132'(if_m.xfer_cnt), 132'(17));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_array.md
SBOX_ARRAY -- requirements
Module: sbox_array

Interface
REQ-001 Parameter LANES, default 4: number of byte lanes substituted in parallel; legal range 1..16.
REQ-002 Parameter CNT_W, default 16: width of the completed-transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 in_inv  input  1  mode: 0 = forward AES S-box, 1 = inverse S-box.
REQ-008 in_data  input  8*LANES  lane k = bits [8k+7:8k].
REQ-009 out_valid  output  1  result word present.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_inv  output  1  mode tag travelling with out_data.
REQ-012 out_data  output  8*LANES  substituted lanes, same lane order as in_data.
REQ-013 xfer_cnt  output  CNT_W  number of output handshakes completed since reset.

Function
REQ-014 Tables: forward table = FIPS-197 S-box, inverse table = FIPS-197 inverse S-box, all 256 entries bit-exact, e.g. S(0x00)=0x63, S(0x0c)=0xfe, S(0x53)=0xed, InvS(0x63)=0x00, InvS(0xed)=0x53.
REQ-015 Each lane is substituted independently with the table selected by the word's in_inv value; no cross-lane interaction.
REQ-016 Two-stage pipeline: stage 1 registers in_data/in_inv; stage 2 registers the looked-up result and the mode tag; out_data/out_inv/out_valid come directly from stage-2 registers.
REQ-017 Input handshake: a word is accepted when in_valid and in_ready are both 1; output handshake occurs when out_valid and out_ready are both 1.
REQ-018 Latency: with out_ready held at 1, an accepted word appears on out_data exactly 2 cycles after the accepting edge; throughput is 1 word per cycle.
REQ-019 stall = out_valid and not out_ready; stage 2 loads only when not stall; stage 1 loads when stage 1 is empty or not stall.
REQ-020 in_ready = (stage 1 empty) or (not stall); in_ready is a function of registered state and out_ready only, never of in_valid.
REQ-021 While stalled, out_data, out_inv, and out_valid hold their values unchanged, and no accepted word is dropped, duplicated, or reordered.
REQ-022 Stage valid bits clear when their word moves on and no new word replaces it; bubbles propagate without producing an output handshake.
REQ-023 The mode may change on every accepted word; each result uses the mode of its own word.
REQ-024 xfer_cnt increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
REQ-025 Values on in_data/in_inv when in_valid=0 have no effect on any state.

Reset
REQ-026 rst_n=0 immediately clears stage-1 valid, stage-2 valid, and xfer_cnt, without waiting for clk; out_valid=0, out_data=0, out_inv=0, xfer_cnt=0.
REQ-027 While rst_n=0, in_ready=0; it rises in the first cycle after rst_n deasserts.
REQ-028 Reset mid-operation discards all in-flight words; after release, no stale word appears on the output.

Verification
REQ-029 Exhaustive: LANES=4, out_ready=1, feed bytes 0x00..0xff in both modes -> every lane matches FIPS-197 tables, and forward(0x0c)=0xfe; output arrives 2 cycles after each accept.
REQ-030 Round trip: forward word 0x00_53_0c_ff, then feed its result inverse -> output 0x00_53_0c_ff; out_inv tags 0 then 1.
REQ-031 Backpressure: stream 10 words with out_ready toggling pseudo-randomly -> all 10 emerged in order, none lost or duplicated, outputs stable during stalls, in_ready=0 only when both stages are full and stalled.
REQ-032 Full stall: out_ready=0 with continuous in_valid -> exactly 2 words accepted, then in_ready=0; after out_ready=1, those words drain in order, and input acceptance resumes on the same cycle.
REQ-033 Counter wrap: CNT_W=4, 17 output handshakes -> xfer_cnt reads 1.
REQ-034 Async reset: assert rst_n low between clock edges with 2 words in flight -> out_valid=0 and xfer_cnt=0 at once; after release, no output until new input is accepted; also rerun REQ-029 with LANES=1 and LANES=16.
